// File: rtl/ov5640_defs.sv
`default_nettype none
// ============================================================================
// Module   : ov5640_defs (package)
// Purpose  : VGA 640x480@60 timing and 320x240 frame-buffer constants.
// Revision : 1.0
// ============================================================================
package ov5640_defs;

    localparam logic [9:0]  H_ACTIVE = 10'd640;
    localparam logic [9:0]  H_FP     = 10'd16;
    localparam logic [9:0]  H_SYNC   = 10'd96;
    localparam logic [9:0]  H_BP     = 10'd48;
    localparam logic [9:0]  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0]  H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0]  H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;

    localparam logic [9:0]  V_ACTIVE = 10'd480;
    localparam logic [9:0]  V_FP     = 10'd10;
    localparam logic [9:0]  V_SYNC   = 10'd2;
    localparam logic [9:0]  V_BP     = 10'd33;
    localparam logic [9:0]  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0]  V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [16:0] FB_WIDTH  = 17'd320;
    localparam logic [16:0] FB_HEIGHT = 17'd240;
    localparam logic [16:0] FB_DEPTH  = 17'd76800;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } vga_flags_t;

    // Eight 80-pixel bars; bar k drives each colour channel full-on from one bit of k.
    function automatic logic [11:0] bar_colour(input logic [9:0] h);
        logic [2:0] k;
        k = 3'd7;
        if      (h < 10'd80)  k = 3'd0;
        else if (h < 10'd160) k = 3'd1;
        else if (h < 10'd240) k = 3'd2;
        else if (h < 10'd320) k = 3'd3;
        else if (h < 10'd400) k = 3'd4;
        else if (h < 10'd480) k = 3'd5;
        else if (h < 10'd560) k = 3'd6;
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel clock-enable divider, h/v counters and active/sync flags.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import ov5640_defs::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output vga_flags_t flags
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    assign pix_ce = (r_div == c_div_last);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_div <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            r_div <= '0;
            if (h_cnt == H_TOTAL - 10'd1) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        flags         = '0;
        flags.active  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
        flags.hsync_n = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        flags.vsync_n = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    end

endmodule
`default_nettype wire

// File: rtl/ov5640_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : ov5640_vga_scanout
// Purpose  : 320x240 RGB444 frame buffer to 640x480@60 VGA with 2x replication.
//            Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module ov5640_vga_scanout
    import ov5640_defs::*;
#(
    parameter int CLK_DIV = 4,
    parameter int RD_LAT  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern_sel,
`endif
    output logic [16:0] vga_bram_raddr,
    output logic        vga_bram_ren,
    input  logic [11:0] vga_bram_rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    logic       w_pix_ce;
    logic [9:0] w_h_cnt;
    logic [9:0] w_v_cnt;
    vga_flags_t w_flags;
    logic       w_pattern_on;
    logic       w_fetch_slot;
    logic       w_rd_valid;

    logic [16:0] r_raddr;
    logic [16:0] r_line_base;
    logic [11:0] r_pix;
    vga_flags_t  r_stage;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pix_ce    (w_pix_ce),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .flags     (w_flags)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign w_pattern_on = test_pattern_sel;
`else
    assign w_pattern_on = 1'b0;
`endif

    assign w_fetch_slot   = w_pix_ce & w_flags.active;
    assign vga_bram_ren   = w_fetch_slot & ~w_pattern_on;
    assign vga_bram_raddr = r_raddr;
    assign frame_start    = w_pix_ce && (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);

    // raddr always holds the address of the current pixel; blanking lines leave it untouched
    // and the next line's base is loaded on the final blanking pixel.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_raddr     <= '0;
            r_line_base <= '0;
        end else if (w_pix_ce) begin
            if (w_flags.active && w_h_cnt[0] && (w_h_cnt != H_ACTIVE - 10'd1)) begin
                r_raddr <= r_raddr + 17'd1;
            end else if (w_h_cnt == H_TOTAL - 10'd1) begin
                if (w_v_cnt == V_TOTAL - 10'd1) begin
                    r_line_base <= '0;
                    r_raddr     <= '0;
                end else if (w_v_cnt < V_ACTIVE - 10'd1) begin
                    if (w_v_cnt[0]) begin
                        r_line_base <= r_line_base + FB_WIDTH;
                        r_raddr     <= r_line_base + FB_WIDTH;
                    end else begin
                        r_raddr     <= r_line_base;
                    end
                end
            end
        end
    end

    generate
        if (RD_LAT <= 1) begin : g_lat_one
            logic r_ren_d;
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) r_ren_d <= 1'b0;
                else            r_ren_d <= vga_bram_ren;
            end
            assign w_rd_valid = r_ren_d;
        end else begin : g_lat_multi
            logic [RD_LAT-1:0] r_ren_pipe;
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) r_ren_pipe <= '0;
                else            r_ren_pipe <= {r_ren_pipe[RD_LAT-2:0], vga_bram_ren};
            end
            assign w_rd_valid = r_ren_pipe[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_pix <= '0;
        end else if (w_fetch_slot && w_pattern_on) begin
            r_pix <= bar_colour(w_h_cnt);
        end else if (w_rd_valid) begin
            r_pix <= vga_bram_rdata;
        end
    end

    // Flags ride one pixel behind the fetch so colour and syncs leave together.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_stage   <= '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else if (w_pix_ce) begin
            r_stage   <= w_flags;
            vga_hsync <= r_stage.hsync_n;
            vga_vsync <= r_stage.vsync_n;
            {vga_r, vga_g, vga_b} <= r_stage.active ? r_pix : 12'h000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov5640_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov5640_vga_scanout
// Purpose  : Scoreboard bench for the VGA scanout (timing, addressing, data path).
// Revision : 1.0
// ============================================================================
module tb_ov5640_vga_scanout;

    localparam int CD = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [16:0] vga_bram_raddr;
    logic        vga_bram_ren;
    logic [11:0] vga_bram_rdata = 12'h000;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_pattern_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         x;
        int         y;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t        pq[$];
    logic [16:0] aq[$];

    always #5 sys_clk = ~sys_clk;

    ov5640_vga_scanout #(
        .CLK_DIV (CD),
        .RD_LAT  (1)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_sel (test_pattern_sel),
`endif
        .vga_bram_raddr   (vga_bram_raddr),
        .vga_bram_ren     (vga_bram_ren),
        .vga_bram_rdata   (vga_bram_rdata),
        .vga_hsync        (vga_hsync),
        .vga_vsync        (vga_vsync),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .frame_start      (frame_start)
    );

    function automatic logic [11:0] mem_val(input logic [16:0] a);
        logic [11:0] v;
        if (a == 17'd5) return 12'hF0A;
        v = a[11:0] * 12'd37 + 12'h123;
        return v;
    endfunction

    function automatic logic [16:0] exp_addr(input int h, input int v);
        return 17'((v / 2) * 320 + (h / 2));
    endfunction

    // One-cycle-latency frame buffer
    always @(posedge sys_clk) begin
        if (vga_bram_ren) vga_bram_rdata <= mem_val(vga_bram_raddr);
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({vga_hsync, vga_vsync} !== 2'b11) begin
            bad++; $display("FAIL reset_syncs got=%b want=11", {vga_hsync, vga_vsync});
        end
        total++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            bad++; $display("FAIL reset_rgb got=%h want=000", {vga_r, vga_g, vga_b});
        end
        total++;
        if (vga_bram_ren !== 1'b0 || frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_ren_fs got=%b%b want=00", vga_bram_ren, frame_start);
        end
        total++;
        if (vga_bram_raddr !== 17'd0) begin
            bad++; $display("FAIL reset_raddr got=%0d want=0", vga_bram_raddr);
        end
        sys_rst_n = 1'b1;
        for (int k = 1; k <= CD; k++) begin
            @(negedge sys_clk);
            total++;
            if (vga_bram_ren !== (k == CD - 1)) begin
                bad++; $display("FAIL first_pix_ce k=%0d got=%b want=%b", k, vga_bram_ren, (k == CD - 1));
            end
        end
    endtask

    task automatic test_sync_timing();
        logic hs_prev;
        int   last_fall;
        int   nfall;
        int   nfs;
        int   vs_low;
        hs_prev = 1'b1; last_fall = -1; nfall = 0; nfs = 0; vs_low = 0;
        do_reset();
        for (int k = 1; k <= (3 * 800 + 100) * CD; k++) begin
            @(negedge sys_clk);
            if (frame_start) begin
                nfs++;
                total++;
                if (k != CD - 1) begin
                    bad++; $display("FAIL frame_start_time got=%0d want=%0d", k, CD - 1);
                end
            end
            if (!vga_vsync) vs_low++;
            if (hs_prev && !vga_hsync) begin
                total++;
                if (last_fall < 0) begin
                    if (k != (656 + 2) * CD) begin
                        bad++; $display("FAIL hsync_first_fall got=%0d want=%0d", k, (656 + 2) * CD);
                    end
                end else if (k - last_fall != 800 * CD) begin
                    bad++; $display("FAIL hsync_period got=%0d want=%0d", k - last_fall, 800 * CD);
                end
                last_fall = k;
                nfall++;
            end
            if (!hs_prev && vga_hsync) begin
                total++;
                if (k - last_fall != 96 * CD) begin
                    bad++; $display("FAIL hsync_width got=%0d want=%0d", k - last_fall, 96 * CD);
                end
            end
            hs_prev = vga_hsync;
        end
        total++;
        if (nfall != 3) begin bad++; $display("FAIL hsync_count got=%0d want=3", nfall); end
        total++;
        if (nfs != 1) begin bad++; $display("FAIL frame_start_count got=%0d want=1", nfs); end
        total++;
        if (vs_low != 0) begin bad++; $display("FAIL vsync_early got=%0d want=0", vs_low); end
    endtask

    task automatic test_addr();
        int          nren;
        logic [16:0] last_addr;
        logic [16:0] a;
        int          j, h, v;
        nren = 0; last_addr = '0;
        aq.delete();
        do_reset();
        for (int k = 1; k <= 5 * 800 * CD; k++) begin
            @(negedge sys_clk);
            if (k % CD == CD - 1) begin
                j = k / CD; h = j % 800; v = j / 800;
                if (h < 640 && v < 480) aq.push_back(exp_addr(h, v));
                else begin
                    total++;
                    if (vga_bram_raddr !== last_addr) begin
                        bad++; $display("FAIL raddr_hold x=%0d y=%0d got=%0d want=%0d", h, v, vga_bram_raddr, last_addr);
                    end
                end
            end
            if (vga_bram_ren) begin
                nren++;
                total++;
                if (aq.size() == 0) begin
                    bad++; $display("FAIL ren_unexpected k=%0d got=1 want=0", k);
                end else begin
                    a = aq.pop_front();
                    if (vga_bram_raddr !== a) begin
                        bad++; $display("FAIL raddr k=%0d got=%0d want=%0d", k, vga_bram_raddr, a);
                    end
                end
                last_addr = vga_bram_raddr;
            end
        end
        total++;
        if (nren != 5 * 640) begin bad++; $display("FAIL ren_count got=%0d want=%0d", nren, 5 * 640); end
        total++;
        if (aq.size() != 0) begin bad++; $display("FAIL ren_missing got=%0d want=0", aq.size()); end
    endtask

    task automatic test_pixel_data();
        exp_t e;
        int   j, h, v;
        pq.delete();
        do_reset();
        for (int k = 1; k <= 3 * 800 * CD; k++) begin
            @(negedge sys_clk);
            if (k % CD == CD - 1) begin
                j = k / CD; h = j % 800; v = j / 800;
                e.x = h; e.y = v;
                e.rgb = (h < 640 && v < 480) ? mem_val(exp_addr(h, v)) : 12'h000;
                e.hs = !(h >= 656 && h < 752);
                e.vs = !(v >= 490 && v < 492);
                pq.push_back(e);
            end
            if (k % CD == 0 && k >= 2 * CD) begin
                total++;
                if (pq.size() == 0) begin
                    bad++; $display("FAIL pix_queue k=%0d got=empty want=entry", k);
                end else begin
                    e = pq.pop_front();
                    if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hsync !== e.hs || vga_vsync !== e.vs) begin
                        bad++;
                        $display("FAIL pixel x=%0d y=%0d got=%h/%b%b want=%h/%b%b", e.x, e.y,
                                 {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, e.rgb, e.hs, e.vs);
                    end
                    if ((e.x == 10 || e.x == 11) && e.y < 2) begin
                        total++;
                        if ({vga_r, vga_g, vga_b} !== 12'hF0A) begin
                            bad++; $display("FAIL addr5_pixel x=%0d y=%0d got=%h want=f0a", e.x, e.y, {vga_r, vga_g, vga_b});
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int kt;
        kt = ((3 * 800 + 300) + 1) * CD - 1;
        do_reset();
        for (int k = 1; k <= kt; k++) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        total++;
        if ({vga_hsync, vga_vsync, vga_bram_ren, frame_start} !== 4'b1100 || {vga_r, vga_g, vga_b} !== 12'h000
            || vga_bram_raddr !== 17'd0) begin
            bad++;
            $display("FAIL midreset_values got=%b%b%b%b/%h/%0d want=1100/000/0", vga_hsync, vga_vsync,
                     vga_bram_ren, frame_start, {vga_r, vga_g, vga_b}, vga_bram_raddr);
        end
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 3 * CD; k++) begin
            @(negedge sys_clk);
            total++;
            if (vga_bram_ren !== (k % CD == CD - 1)) begin
                bad++; $display("FAIL midreset_ren k=%0d got=%b want=%b", k, vga_bram_ren, (k % CD == CD - 1));
            end
            if (vga_bram_ren) begin
                total++;
                if (vga_bram_raddr !== exp_addr(k / CD, 0)) begin
                    bad++; $display("FAIL midreset_raddr k=%0d got=%0d want=%0d", k, vga_bram_raddr, exp_addr(k / CD, 0));
                end
            end
            total++;
            if (k < 2 * CD && {vga_r, vga_g, vga_b} !== 12'h000) begin
                bad++; $display("FAIL midreset_stale k=%0d got=%h want=000", k, {vga_r, vga_g, vga_b});
            end else if (k == 2 * CD && {vga_r, vga_g, vga_b} !== mem_val(17'd0)) begin
                bad++; $display("FAIL midreset_first_pix got=%h want=%h", {vga_r, vga_g, vga_b}, mem_val(17'd0));
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        exp_t       e;
        int         j, h, nren;
        logic [2:0] bk;
        nren = 0;
        pq.delete();
        test_pattern_sel = 1'b1;
        do_reset();
        for (int k = 1; k <= 801 * CD; k++) begin
            @(negedge sys_clk);
            if (vga_bram_ren) nren++;
            if (k % CD == CD - 1) begin
                j = k / CD; h = j % 800;
                bk = 3'(h / 80);
                e.x = h; e.y = 0; e.hs = 1'b1; e.vs = 1'b1;
                e.rgb = (h < 640) ? {{4{bk[2]}}, {4{bk[1]}}, {4{bk[0]}}} : 12'h000;
                pq.push_back(e);
            end
            if (k % CD == 0 && k >= 2 * CD && pq.size() != 0) begin
                e = pq.pop_front();
                if (e.x < 80 || (e.x >= 560 && e.x < 640)) begin
                    total++;
                    if ({vga_r, vga_g, vga_b} !== e.rgb) begin
                        bad++; $display("FAIL bar x=%0d got=%h want=%h", e.x, {vga_r, vga_g, vga_b}, e.rgb);
                    end
                end
            end
        end
        total++;
        if (nren != 0) begin bad++; $display("FAIL pattern_ren got=%0d want=0", nren); end
        test_pattern_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sync_timing();
        test_addr();
        test_pixel_data();
        test_midframe_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
        test_pixel_data();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
